// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg
//   Shared definitions for the data memory load/store unit:
//   - RV32 funct3 size/sign codes for loads and stores
//   - FSM state encoding for the request handshake
//   - f3_legal(): true for the funct3 codes the unit accepts
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Combinational byte-lane steering between a 32-bit memory word and the core.
//   Ports:
//     i_funct3     in   3   RV32 size/sign code
//     i_addr_lo    in   2   byte offset within the word
//     i_wdata      in   32  right-aligned store data
//     i_raw_word   in   32  memory word addressed by the access
//     o_byte_en    out  4   per-lane write enable (all zero when illegal)
//     o_store_word out  32  store data replicated onto every lane of its size
//     o_load_data  out  32  selected lane, sign- or zero-extended
//     o_misalign   out  1   misaligned address or illegal funct3
module mem_lane_align
  import rv_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_raw_word,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_store_word,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_byte_en    = 4'b0000;
    o_store_word = 32'h0;
    o_load_data  = 32'h0;
    o_misalign   = 1'b0;
    w_byte       = i_raw_word[{i_addr_lo, 3'b000} +: 8];
    w_half       = i_raw_word[{i_addr_lo[1], 4'b0000} +: 16];

    case (i_funct3)
      F3_B, F3_BU: begin
        o_byte_en    = 4'b0001 << i_addr_lo;
        // Replicating the byte onto every lane lets the enable alone pick the target lane.
        o_store_word = {4{i_wdata[7:0]}};
        o_load_data  = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end
      F3_H, F3_HU: begin
        if (i_addr_lo[0]) begin
          o_misalign = 1'b1;
        end else begin
          o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
          o_store_word = {2{i_wdata[15:0]}};
          o_load_data  = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
        end
      end
      F3_W: begin
        if (i_addr_lo != 2'b00) begin
          o_misalign = 1'b1;
        end else begin
          o_byte_en    = 4'b1111;
          o_store_word = i_wdata;
          o_load_data  = i_raw_word;
        end
      end
      default: o_misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu
//   Byte-addressed, word-organised data memory with a req/ready handshake and a
//   programmable number of wait states. Supports LB/LH/LW/LBU/LHU/SB/SH/SW.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      asynchronous active-high reset
//     req        in   1      access request, sampled only in IDLE
//     MemWrite   in   1      1 = store, 0 = load
//     funct3     in   3      RV32 size/sign code
//     address    in   Width  byte address (wraps modulo 4*MemNum)
//     WriteData  in   Width  right-aligned store data
//     ready      out  1      one-cycle completion pulse
//     ReadData   out  Width  load result, held until the next ready
//     misalign   out  1      with ready: misaligned or illegal access
//     busy       out  1      high whenever the FSM is not in IDLE
module data_mem_lsu
  import rv_mem_pkg::*;
#(
  parameter int Width      = 32,
  parameter int MemNum     = 512,
  parameter int WaitCycles = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             MemWrite,
  input  logic [2:0]       funct3,
  input  logic [Width-1:0] address,
  input  logic [Width-1:0] WriteData,
  output logic             ready,
  output logic [Width-1:0] ReadData,
  output logic             misalign,
  output logic             busy
);

  localparam int         IdxW     = $clog2(MemNum);
  localparam logic [3:0] WaitLoad = (WaitCycles == 0) ? 4'd0 : 4'(WaitCycles - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [3:0]         r_cnt;
  logic               r_we;
  logic [2:0]         r_funct3;
  logic [IdxW+1:0]    r_addr;
  logic [Width-1:0]   r_wdata;
  logic [Width-1:0]   r_rdata;
  logic               r_misalign;
  logic [Width-1:0]   r_mem [MemNum];

  logic               w_enter_done;
  logic               w_cur_we;
  logic [2:0]         w_cur_funct3;
  logic [IdxW+1:0]    w_cur_addr;
  logic [Width-1:0]   w_cur_wdata;
  logic [IdxW-1:0]    w_cur_idx;
  logic [3:0]         w_byte_en;
  logic [Width-1:0]   w_store_word;
  logic [Width-1:0]   w_load_data;
  logic               w_misalign;
  logic               w_unused;

  // Address bits above the array size are ignored so accesses wrap.
  assign w_unused = ^address[Width-1:IdxW+2];

  // With zero wait states DONE is entered on the accept edge itself, before the
  // request latches hold anything, so the live inputs must drive the datapath.
  always_comb begin
    if (r_state == IDLE) begin
      w_cur_we     = MemWrite;
      w_cur_funct3 = funct3;
      w_cur_addr   = address[IdxW+1:0];
      w_cur_wdata  = WriteData;
    end else begin
      w_cur_we     = r_we;
      w_cur_funct3 = r_funct3;
      w_cur_addr   = r_addr;
      w_cur_wdata  = r_wdata;
    end
  end

  assign w_cur_idx = w_cur_addr[IdxW+1:2];

  mem_lane_align u_align (
    .i_funct3     (w_cur_funct3),
    .i_addr_lo    (w_cur_addr[1:0]),
    .i_wdata      (w_cur_wdata),
    .i_raw_word   (r_mem[w_cur_idx]),
    .o_byte_en    (w_byte_en),
    .o_store_word (w_store_word),
    .o_load_data  (w_load_data),
    .o_misalign   (w_misalign)
  );

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (req) w_state_next = (WaitCycles == 0) ? DONE : WAIT;
      WAIT:    if (r_cnt == 4'd0) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_enter_done = (w_state_next == DONE) && (r_state != DONE);

  // State register, wait counter, request latches and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_we     <= MemWrite;
            r_funct3 <= funct3;
            r_addr   <= address[IdxW+1:0];
            r_wdata  <= WriteData;
            r_cnt    <= WaitLoad;
          end
        end
        WAIT: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        default: ;
      endcase
      if (w_enter_done) begin
        r_misalign <= w_misalign;
        // A legal store leaves the previous load result on ReadData.
        if (w_misalign) r_rdata <= '0;
        else if (!w_cur_we) r_rdata <= w_load_data;
      end
    end
  end

  // Array: byte-lane masked write on the edge entering DONE. An async reset
  // forces IDLE, so a store interrupted by reset never reaches this edge.
  always_ff @(posedge clk) begin
    if (w_enter_done && w_cur_we && !w_misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (w_byte_en[b]) r_mem[w_cur_idx][8*b +: 8] <= w_store_word[8*b +: 8];
      end
    end
  end

  // Outputs
  always_comb begin
    ready = (r_state == DONE);
    busy  = (r_state != IDLE);
  end

  assign ReadData = r_rdata;
  assign misalign = r_misalign;

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;
  import rv_mem_pkg::*;

  localparam int MEMNUM = 512;
  localparam int WC     = 2;
  localparam int SWEEP_W [3] = '{0, 1, 15};

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, req, mem_write, sreq;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic        ready, misalign, busy;
  logic [31:0] rdata;
  logic        s_ready [3];
  logic        s_mis [3];
  logic        s_busy [3];
  logic [31:0] s_unused_rdata [3];

  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          busy_from = -100;
  int          busy_until = -100;
  logic [31:0] last_rd = 32'h0;
  logic [7:0]  ref_mem [4*MEMNUM];
  exp_t        sb [$];
  string       sb_name [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_lsu #(.Width(32), .MemNum(MEMNUM), .WaitCycles(WC)) dut (
    .clk(clk), .rst(rst), .req(req), .MemWrite(mem_write), .funct3(f3),
    .address(addr), .WriteData(wdata), .ready(ready), .ReadData(rdata),
    .misalign(misalign), .busy(busy)
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
    data_mem_lsu #(.Width(32), .MemNum(MEMNUM), .WaitCycles(SWEEP_W[gi])) u_s (
      .clk(clk), .rst(rst), .req(sreq), .MemWrite(1'b0), .funct3(F3_W),
      .address(32'h0), .WriteData(32'h0), .ready(s_ready[gi]),
      .ReadData(s_unused_rdata[gi]), .misalign(s_mis[gi]), .busy(s_busy[gi])
    );
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  // ---------------- reference model: little-endian byte array ----------------
  function automatic int bidx(input logic [31:0] a);
    return int'(a & 32'(4*MEMNUM - 1));
  endfunction

  function automatic logic is_legal(input logic [2:0] f, input logic [31:0] a);
    if (f == F3_B || f == F3_BU) return 1'b1;
    if (f == F3_H || f == F3_HU) return (a % 2) == 0;
    if (f == F3_W) return (a % 4) == 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f, input logic [31:0] a);
    int b;
    logic [7:0] b0, b1;
    b  = bidx(a);
    b0 = ref_mem[b];
    b1 = ref_mem[(b + 1) % (4*MEMNUM)];
    case (f)
      F3_B:    return {{24{b0[7]}}, b0};
      F3_BU:   return {24'h0, b0};
      F3_H:    return {{16{b1[7]}}, b1, b0};
      F3_HU:   return {16'h0, b1, b0};
      default: return {ref_mem[b+3], ref_mem[b+2], b1, b0};
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
    int n;
    int b;
    n = (f == F3_W) ? 4 : (f == F3_H) ? 2 : 1;
    b = bidx(a);
    for (int k = 0; k < n; k++) ref_mem[b + k] = d[8*k +: 8];
  endtask

  // ---------------- driver ----------------
  task automatic access(input logic we, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input string nm,
                        input bit use_lit, input logic [31:0] lit);
    exp_t e;
    int   p;
    e.mis = !is_legal(f, a);
    if (e.mis) last_rd = 32'h0;
    else if (we) model_store(f, a, d);
    else last_rd = use_lit ? lit : model_load(f, a);
    e.rd = last_rd;
    @(negedge clk);
    req = 1'b1; mem_write = we; f3 = f; addr = a; wdata = d;
    p = cyc;
    e.cyc = 32'(p + 1 + WC);
    busy_from  = p + 1;
    busy_until = p + 1 + WC;
    sb.push_back(e);
    sb_name.push_back(nm);
    @(negedge clk);
    req = 1'b0;
    while (cyc < p + 2 + WC) @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      check($sformatf("busy@%0d", cyc), 32'(busy),
            32'((cyc >= busy_from) && (cyc <= busy_until)));
      if (ready === 1'b1) begin
        if (sb.size() == 0) begin
          check($sformatf("spurious_ready@%0d", cyc), 32'(ready), 32'h0);
        end else begin
          e  = sb.pop_front();
          nm = sb_name.pop_front();
          $display("txn %s: ReadData=0x%08h misalign=%0b cycle=%0d", nm, rdata, misalign, cyc);
          check({nm, " data"}, rdata, e.rd);
          check({nm, " misalign"}, 32'(misalign), 32'(e.mis));
          check({nm, " latency"}, 32'(cyc), e.cyc);
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, required end before 200000ns");
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        we;
    logic [2:0]  f;
    logic [31:0] a, d;
    int          sel, p0, ph, p;

    rst = 1'b1; req = 1'b0; sreq = 1'b0; mem_write = 1'b0;
    f3 = F3_W; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset ready", 32'(ready), 32'h0);
    check("reset ReadData", rdata, 32'h0);
    check("reset misalign", 32'(misalign), 32'h0);
    check("reset busy", 32'(busy), 32'h0);

    // Preload words touched by directed and random tests.
    access(1'b1, F3_W, 32'h20, 32'h11223344, "pre SW 0x20", 0, 0);
    access(1'b1, F3_W, 32'h30, 32'hCAFEF00D, "pre SW 0x30", 0, 0);
    for (int i = 0; i < 16; i++)
      access(1'b1, F3_W, 32'h100 + 32'(4*i), $urandom, "pre SW win", 0, 0);

    // 1: word store / load
    access(1'b1, F3_W, 32'h10, 32'hDEADBEEF, "t1 SW", 0, 0);
    access(1'b0, F3_W, 32'h10, 32'h0, "t1 LW", 1, 32'hDEADBEEF);
    // 2: byte store and byte loads
    access(1'b1, F3_B, 32'h12, 32'hAAAAAA7F, "t2 SB", 0, 0);
    access(1'b0, F3_W, 32'h10, 32'h0, "t2 LW", 1, 32'hDE7FBEEF);
    access(1'b0, F3_B, 32'h13, 32'h0, "t2 LB", 1, 32'hFFFFFFDE);
    access(1'b0, F3_BU, 32'h13, 32'h0, "t2 LBU", 1, 32'h000000DE);
    // 3: halfword store and halfword loads
    access(1'b1, F3_H, 32'h22, 32'h55558001, "t3 SH", 0, 0);
    access(1'b0, F3_H, 32'h22, 32'h0, "t3 LH", 1, 32'hFFFF8001);
    access(1'b0, F3_HU, 32'h22, 32'h0, "t3 LHU", 1, 32'h00008001);
    access(1'b0, F3_W, 32'h20, 32'h0, "t3 LW", 1, 32'h80013344);
    // 4: misaligned and illegal accesses
    access(1'b1, F3_W, 32'h31, 32'h12345678, "t4 SW mis", 0, 0);
    access(1'b0, F3_H, 32'h33, 32'h0, "t4 LH mis", 0, 0);
    access(1'b0, F3_W, 32'h30, 32'h0, "t4 LW 0x30", 1, 32'hCAFEF00D);
    access(1'b0, 3'b011, 32'h30, 32'h0, "t4 f3=011", 0, 0);
    access(1'b1, 3'b110, 32'h30, 32'hFFFFFFFF, "t4 f3=110 st", 0, 0);
    access(1'b0, F3_W, 32'h30, 32'h0, "t4 LW 0x30 again", 1, 32'hCAFEF00D);

    // 5: wrap, then a wrapped store aborted by reset in WAIT
    access(1'b1, F3_W, 32'h10 + 32'(4*MEMNUM), 32'hA5A5A5A5, "t5 SW wrap", 0, 0);
    access(1'b0, F3_W, 32'h10, 32'h0, "t5 LW wrap", 1, 32'hA5A5A5A5);
    access(1'b1, F3_W, 32'h10, 32'h12345678, "t5 SW", 0, 0);
    @(negedge clk);
    req = 1'b1; mem_write = 1'b1; f3 = F3_W; addr = 32'h10 + 32'(4*MEMNUM); wdata = 32'hA5A5A5A5;
    p = cyc;
    busy_from = p + 1; busy_until = p + 1 + WC;
    @(negedge clk);
    req = 1'b0;
    #2;
    rst = 1'b1;
    busy_until = cyc;
    last_rd = 32'h0;
    #1;
    check("t5 rst busy", 32'(busy), 32'h0);
    check("t5 rst ready", 32'(ready), 32'h0);
    check("t5 rst ReadData", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    access(1'b0, F3_W, 32'h10, 32'h0, "t5 LW after rst", 1, 32'h12345678);
    access(1'b0, F3_W, 32'h10 + 32'(4*MEMNUM), 32'h0, "t5 LW wrap after rst", 1, 32'h12345678);

    // Random accesses in a preloaded window, including wrapped aliases.
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom_range(0, 1));
      a   = 32'h100 + 32'($urandom_range(0, 63)) + 32'(4*MEMNUM*$urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      d   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: f = F3_B;
        3, 4:    f = F3_H;
        5, 6:    f = F3_W;
        7:       f = we ? F3_B : F3_BU;
        8:       f = we ? F3_H : F3_HU;
        default: f = ($urandom_range(0, 2) == 0) ? 3'b011 : ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111;
      endcase
      access(we, f, a, d, $sformatf("rnd%0d %s f3=%0d @0x%0h", i, we ? "ST" : "LD", f, a), 0, 0);
    end

    // 6: back-to-back with req held high on instances with different wait counts
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("sweep W=%0d idle busy", SWEEP_W[i]), 32'(s_busy[i]), 32'h0);
    sreq = 1'b1;
    p0 = cyc;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        ph = (cyc - (p0 + 1)) % (SWEEP_W[i] + 2);
        check($sformatf("sweep W=%0d ready@%0d", SWEEP_W[i], k), 32'(s_ready[i]), 32'(ph == SWEEP_W[i]));
        check($sformatf("sweep W=%0d busy@%0d", SWEEP_W[i], k), 32'(s_busy[i]), 32'(ph != SWEEP_W[i] + 1));
        if (ph == SWEEP_W[i])
          check($sformatf("sweep W=%0d misalign@%0d", SWEEP_W[i], k), 32'(s_mis[i]), 32'h0);
      end
    end
    sreq = 1'b0;

    repeat (20) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
